// File: rtl/exhaustive_vec_checker.sv
// exhaustive_vec_checker: sweeps every N_IN-bit vector into a combinational DUT and counts mismatches against a reference.
// Optional STOP_ON_ERR_EN: end the run at the first mismatch.
module exhaustive_vec_checker #(
  parameter int N_IN = 4,
  parameter int SETTLE = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      vec_out,
  input  logic                 dut_f,
  input  logic                 ref_f,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [N_IN-1:0]      first_err_vec,
  output logic                 first_err_valid
);
  localparam int CW = $clog2(SETTLE + 1);
  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic mis;
  // Case inequality so an X/Z on either function output counts as a mismatch.
  assign mis = dut_f !== ref_f;
  assign busy = state == WAIT || state == CHECK;
  assign done = state == DONE;
  assign pass = done && err_count == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vec_out <= '0;
      cnt <= '0;
      err_count <= '0;
      first_err_vec <= '0;
      first_err_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          vec_out <= '0;
          cnt <= '0;
          err_count <= '0;
          first_err_vec <= '0;
          first_err_valid <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(SETTLE - 1)) state <= CHECK;
        end
        CHECK: begin
          if (mis) begin
            err_count <= &err_count ? err_count : err_count + 1'b1;
            if (!first_err_valid) begin
              first_err_vec <= vec_out;
              first_err_valid <= 1'b1;
            end
          end
`ifdef STOP_ON_ERR_EN
          if (mis) state <= DONE;
          else
`endif
          if (&vec_out) state <= DONE;
          else begin
            vec_out <= vec_out + 1'b1;
            cnt <= '0;
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
